// File: rtl/i2c_csr_pkg.sv
// Shared types and constants for the I2C-to-CSR bridge.
package i2c_csr_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } state_t;

    localparam logic ACK    = 1'b0;
    localparam logic NACK   = 1'b1;
    localparam int   BCNT_W = 3;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises the raw SCL/SDA pads and decodes SCL edges and START/STOP.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [1:0] scl_ff;
    logic [1:0] sda_ff;
    logic       scl_h;
    logic       sda_h;

    // Reset to 1 so an idle bus produces no spurious edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_ff <= 2'b11;
            sda_ff <= 2'b11;
            scl_h  <= 1'b1;
            sda_h  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[0], scl_in};
            sda_ff <= {sda_ff[0], sda_in};
            scl_h  <= scl_ff[1];
            sda_h  <= sda_ff[1];
        end
    end

    assign sda_s     = sda_ff[1];
    assign scl_rise  =  scl_ff[1] & ~scl_h;
    assign scl_fall  = ~scl_ff[1] &  scl_h;
    assign start_det =  scl_ff[1] &  scl_h &  sda_h & ~sda_ff[1];
    assign stop_det  =  scl_ff[1] &  scl_h & ~sda_h &  sda_ff[1];

endmodule

// File: rtl/i2c_csr_bridge.sv
// I2C target translating host transactions into CSR reads and writes.
module i2c_csr_bridge
    import i2c_csr_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = 7'h4a,
    parameter int         CSR_AW   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic [CSR_AW-1:0] csr_a,
    output logic [7:0]        csr_di,
    output logic              csr_we,
    input  logic [7:0]        csr_do
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    state_t              state;
    logic [BCNT_W-1:0]   cnt;
    logic [7:0]          shreg;
    logic [7:0]          rx_byte;
    logic [CSR_AW-1:0]   ptr;
    logic                rw;
    logic                ack_on;

    assign rx_byte = {shreg[6:0], sda_s};
    assign csr_a   = ptr;

    // Each *_ACK state sees two SCL falls: the first opens the ACK slot,
    // the second (ack_on set) closes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            shreg  <= '0;
            ptr    <= '0;
            rw     <= 1'b0;
            ack_on <= 1'b0;
            sda_oe <= 1'b0;
            csr_di <= '0;
            csr_we <= 1'b0;
        end else begin
            csr_we <= 1'b0;
            if (csr_we)
                ptr <= ptr + 1'b1;

            if (start_det) begin
                state  <= ADDR;
                cnt    <= '0;
                ack_on <= 1'b0;
                sda_oe <= 1'b0;
            end else if (stop_det) begin
                state  <= IDLE;
                ack_on <= 1'b0;
                sda_oe <= 1'b0;
            end else begin
                case (state)
                    ADDR, PTR, WDATA: begin
                        if (scl_rise) begin
                            shreg <= rx_byte;
                            cnt   <= cnt + 1'b1;
                            if (&cnt) begin
                                ack_on <= 1'b0;
                                case (state)
                                    ADDR: begin
                                        if (rx_byte[7:1] == I2C_ADDR) begin
                                            rw    <= rx_byte[0];
                                            state <= ADDR_ACK;
                                        end else begin
                                            state <= IGNORE;
                                        end
                                    end
                                    PTR: begin
                                        ptr   <= rx_byte[CSR_AW-1:0];
                                        state <= PTR_ACK;
                                    end
                                    default: state <= WDATA_ACK;
                                endcase
                            end
                        end
                    end

                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_on) begin
                                sda_oe <= 1'b1;
                                ack_on <= 1'b1;
                            end else begin
                                ack_on <= 1'b0;
                                cnt    <= '0;
                                if (rw) begin
                                    shreg  <= {csr_do[6:0], 1'b0};
                                    sda_oe <= ~csr_do[7];
                                    state  <= RDATA;
                                end else begin
                                    sda_oe <= 1'b0;
                                    state  <= PTR;
                                end
                            end
                        end
                    end

                    PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!ack_on) begin
                                sda_oe <= 1'b1;
                                ack_on <= 1'b1;
                                if (state == WDATA_ACK) begin
                                    csr_di <= shreg;
                                    csr_we <= 1'b1;
                                end
                            end else begin
                                sda_oe <= 1'b0;
                                ack_on <= 1'b0;
                                cnt    <= '0;
                                state  <= WDATA;
                            end
                        end
                    end

                    RDATA: begin
                        if (scl_rise) begin
                            cnt <= cnt + 1'b1;
                            if (&cnt) begin
                                ack_on <= 1'b0;
                                state  <= RDATA_ACK;
                            end
                        end else if (scl_fall) begin
                            sda_oe <= ~shreg[7];
                            shreg  <= {shreg[6:0], 1'b0};
                        end
                    end

                    RDATA_ACK: begin
                        if (scl_fall && !ack_on) begin
                            sda_oe <= 1'b0;
                            ack_on <= 1'b1;
                        end else if (scl_rise && ack_on) begin
                            ptr <= ptr + 1'b1;
                            if (sda_s == NACK)
                                state <= IGNORE;
                        end else if (scl_fall && ack_on) begin
                            // ptr has already advanced, so csr_do is the next byte
                            ack_on <= 1'b0;
                            cnt    <= '0;
                            shreg  <= {csr_do[6:0], 1'b0};
                            sda_oe <= ~csr_do[7];
                            state  <= RDATA;
                        end
                    end

                    default: ;
                endcase
            end
        end
    end

endmodule
